// File: rtl/ram_dp_clr_if.sv
// ram_dp_clr_if: user-side bus of the dual-port clearable RAM.
// Both ports plus the clear request/busy pair travel together.
interface ram_dp_clr_if #(
   parameter int addr_width_g = 11,
   parameter int data_width_g = 8
);
   logic                    clear_req;
   logic                    busy;
   logic [addr_width_g-1:0] address_a;
   logic [data_width_g-1:0] data_a;
   logic                    wren_a;
   logic [data_width_g-1:0] q_a;
   logic [addr_width_g-1:0] address_b;
   logic [data_width_g-1:0] data_b;
   logic                    wren_b;
   logic [data_width_g-1:0] q_b;

   modport master (
      output clear_req,
      output address_a, data_a, wren_a,
      output address_b, data_b, wren_b,
      input  busy, q_a, q_b
   );

   modport slave (
      input  clear_req,
      input  address_a, data_a, wren_a,
      input  address_b, data_b, wren_b,
      output busy, q_a, q_b
   );
endinterface

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: true dual-port block RAM with a hardware clear sweep.
// Port A wins write collisions; the sweep borrows port A's write path.
module ram_dp_clr #(
   parameter int          addr_width_g  = 11,
   parameter int          data_width_g  = 8,
   parameter int          rdw_mode_g    = 0,
   parameter int unsigned clear_value_g = 0
) (
   input logic        clock,
   input logic        reset,
   ram_dp_clr_if.slave bus
);
   localparam int depth_c = 2 ** addr_width_g;
   localparam bit rdw_c   = (rdw_mode_g != 0);
   localparam logic [data_width_g-1:0] clr_c =
      data_width_g'(clear_value_g);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                  state;
   logic [addr_width_g-1:0] count;
   logic                    busy_r;

   logic [data_width_g-1:0] ram [depth_c];
   logic [data_width_g-1:0] rd_a;
   logic [data_width_g-1:0] rd_b;

   logic                    zero_r;
   logic                    byp_a;
   logic                    byp_b;
   logic [data_width_g-1:0] byp_d_a;
   logic [data_width_g-1:0] byp_d_b;

   logic                    start;
   logic                    user_a;
   logic                    user_b;
   logic                    clash;
   logic                    we_a;
   logic                    we_b;
   logic [addr_width_g-1:0] wa_addr;
   logic [data_width_g-1:0] wa_data;

   always_comb begin
      start   = (state == IDLE) && bus.clear_req;
      user_a  = !busy_r && !reset && bus.wren_a;
      user_b  = !busy_r && !reset && bus.wren_b;
      clash   = user_a && user_b &&
                (bus.address_a == bus.address_b);
      we_a    = (busy_r && !reset) || user_a;
      we_b    = user_b && !clash;
      wa_addr = busy_r ? count : bus.address_a;
      wa_data = busy_r ? clr_c : bus.data_a;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= CLEAR;
         count  <= '0;
         busy_r <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state  <= CLEAR;
                  count  <= '0;
                  busy_r <= 1'b1;
               end
            end
            CLEAR: begin
               count <= count + 1'b1;
               if (count == '1) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end
            end
            default: begin
               state  <= CLEAR;
               count  <= '0;
               busy_r <= 1'b1;
            end
         endcase
      end
   end

   // Plain array, no reset: keeps the block RAM inferable.
   always_ff @(posedge clock) begin
      if (we_a)
         ram[wa_addr] <= wa_data;
      if (we_b)
         ram[bus.address_b] <= bus.data_b;
      rd_a <= ram[bus.address_a];
      rd_b <= ram[bus.address_b];
   end

   // Output steering: forced zero while clearing, else bypass or RAM.
   always_ff @(posedge clock) begin
      if (reset) begin
         zero_r  <= 1'b1;
         byp_a   <= 1'b0;
         byp_b   <= 1'b0;
         byp_d_a <= '0;
         byp_d_b <= '0;
      end else begin
         zero_r  <= busy_r || start;
         byp_a   <= rdw_c && user_a;
         byp_b   <= rdw_c && user_b;
         byp_d_a <= bus.data_a;
         byp_d_b <= clash ? bus.data_a : bus.data_b;
      end
   end

   assign bus.busy = busy_r;
   assign bus.q_a  = zero_r ? '0 : (byp_a ? byp_d_a : rd_a);
   assign bus.q_b  = zero_r ? '0 : (byp_b ? byp_d_b : rd_b);
endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: scoreboard bench, two DUTs driven in lockstep.
// d0: old-data RDW, clear 0x00; d1: new-data RDW, clear 0x80.
module tb_ram_dp_clr;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       clear_req = 1'b0;
   logic [3:0] address_a = '0;
   logic [7:0] data_a = '0;
   logic       wren_a = 1'b0;
   logic [3:0] address_b = '0;
   logic [7:0] data_b = '0;
   logic       wren_b = 1'b0;
   logic       rd_a = 1'b0;
   logic       rd_b = 1'b0;
   logic       pend_a = 1'b0;
   logic       pend_b = 1'b0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      nm;
      logic [7:0] e0;
      logic [7:0] e1;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   ram_dp_clr_if #(.addr_width_g(4), .data_width_g(8)) i0 ();
   ram_dp_clr_if #(.addr_width_g(4), .data_width_g(8)) i1 ();

   assign i0.clear_req = clear_req;
   assign i0.address_a = address_a;
   assign i0.data_a    = data_a;
   assign i0.wren_a    = wren_a;
   assign i0.address_b = address_b;
   assign i0.data_b    = data_b;
   assign i0.wren_b    = wren_b;
   assign i1.clear_req = clear_req;
   assign i1.address_a = address_a;
   assign i1.data_a    = data_a;
   assign i1.wren_a    = wren_a;
   assign i1.address_b = address_b;
   assign i1.data_b    = data_b;
   assign i1.wren_b    = wren_b;

   ram_dp_clr #(
      .addr_width_g(4), .data_width_g(8),
      .rdw_mode_g(0), .clear_value_g(32'h00)
   ) d0 (
      .clock(clock), .reset(reset), .bus(i0)
   );

   ram_dp_clr #(
      .addr_width_g(4), .data_width_g(8),
      .rdw_mode_g(1), .clear_value_g(32'h80)
   ) d1 (
      .clock(clock), .reset(reset), .bus(i1)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   always @(posedge clock) begin
      pend_a <= rd_a;
      pend_b <= rd_b;
   end

   // Monitor: q is due on the negedge after the edge that took the read.
   always @(negedge clock) begin
      exp_t e;
      if (pend_a) begin
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL qa_empty: got read want queued entry");
         end else begin
            e = qa.pop_front();
            check({e.nm, "_a0"}, int'(i0.q_a), int'(e.e0));
            check({e.nm, "_a1"}, int'(i1.q_a), int'(e.e1));
         end
      end
      if (pend_b) begin
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL qb_empty: got read want queued entry");
         end else begin
            e = qb.pop_front();
            check({e.nm, "_b0"}, int'(i0.q_b), int'(e.e0));
            check({e.nm, "_b1"}, int'(i1.q_b), int'(e.e1));
         end
      end
   end

   task automatic rdab(input string nm,
                       input logic [3:0] aa, input logic [3:0] ab,
                       input logic [7:0] ea0, input logic [7:0] ea1,
                       input logic [7:0] eb0, input logic [7:0] eb1);
      address_a = aa;
      address_b = ab;
      rd_a = 1'b1;
      rd_b = 1'b1;
      qa.push_back('{nm, ea0, ea1});
      qb.push_back('{nm, eb0, eb1});
      tick();
      rd_a = 1'b0;
      rd_b = 1'b0;
   endtask

   task automatic wr(input logic ea, input logic [3:0] aa,
                     input logic [7:0] da, input logic eb,
                     input logic [3:0] ab, input logic [7:0] db);
      wren_a = ea;
      address_a = aa;
      data_a = da;
      wren_b = eb;
      address_b = ab;
      data_b = db;
      tick();
      wren_a = 1'b0;
      wren_b = 1'b0;
   endtask

   // Counts busy cycles and flags any nonzero q while busy.
   task automatic busy_len(input string nm, input bit pulse);
      int n0 = 0;
      int n1 = 0;
      int qbad = 0;
      for (int k = 0; k < 40 && (i0.busy || i1.busy); k++) begin
         n0 += int'(i0.busy);
         n1 += int'(i1.busy);
         if (i0.busy && (i0.q_a != 0 || i0.q_b != 0)) qbad++;
         if (i1.busy && (i1.q_a != 0 || i1.q_b != 0)) qbad++;
         clear_req = pulse && (k == 5);
         tick();
      end
      clear_req = 1'b0;
      check({nm, "_busy0"}, n0, 16);
      check({nm, "_busy1"}, n1, 16);
      check({nm, "_qzero"}, qbad, 0);
   endtask

   initial begin
      reset = 1'b1;
      tick();
      check("rst_busy0", int'(i0.busy), 1);
      check("rst_busy1", int'(i1.busy), 1);
      check("rst_q0", int'(i0.q_a), 0);
      check("rst_q1", int'(i1.q_b), 0);
      reset = 1'b0;
      busy_len("rst", 1'b0);

      for (int i = 0; i < 16; i++)
         rdab("rclr", 4'(i), 4'(15 - i), 8'h00, 8'h80, 8'h00, 8'h80);

      wr(1'b1, 4'd3, 8'hA5, 1'b1, 4'd7, 8'h5A);
      rdab("dual", 4'd7, 4'd3, 8'h5A, 8'h5A, 8'hA5, 8'hA5);

      wren_a = 1'b1; data_a = 8'h11;
      wren_b = 1'b1; data_b = 8'h22;
      rdab("col", 4'd9, 4'd9, 8'h00, 8'h11, 8'h00, 8'h11);
      wren_a = 1'b0; wren_b = 1'b0;
      rdab("col_rd", 4'd9, 4'd9, 8'h11, 8'h11, 8'h11, 8'h11);

      wr(1'b1, 4'd5, 8'h33, 1'b0, 4'd0, 8'h00);
      wren_a = 1'b1; data_a = 8'h44;
      rdab("rdw", 4'd5, 4'd5, 8'h33, 8'h44, 8'h33, 8'h33);
      wren_a = 1'b0;
      rdab("rdw_rd", 4'd5, 4'd5, 8'h44, 8'h44, 8'h44, 8'h44);

      for (int i = 0; i < 16; i++)
         wr(1'b1, 4'(i), 8'hFF, 1'b0, 4'd0, 8'h00);
      rdab("fill", 4'd2, 4'd14, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      wren_a = 1'b1; address_a = 4'd2; data_a = 8'h01;
      busy_len("creq", 1'b0);
      wren_a = 1'b0;
      for (int i = 0; i < 16; i++)
         rdab("cclr", 4'(i), 4'(15 - i), 8'h00, 8'h80, 8'h00, 8'h80);

      wr(1'b1, 4'd12, 8'h99, 1'b1, 4'd0, 8'h66);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      busy_len("mid", 1'b1);
      rdab("mid_rd", 4'd12, 4'd0, 8'h00, 8'h80, 8'h00, 8'h80);
      wr(1'b1, 4'd4, 8'h77, 1'b0, 4'd0, 8'h00);
      rdab("post", 4'd4, 4'd15, 8'h77, 8'h77, 8'h00, 8'h80);

      tick();
      tick();
      check("drain", qa.size() + qb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
- Parametrised true dual-port synchronous block RAM with two independent read/write ports on one clock.
- Built-in clear sequencer fills every location with a fixed value after reset or on request.
- Used for sprite/tile work RAMs that the CPU and video side both access and that must start from a known state.
- Successor to the single-port 1-cycle-read RAM. Adds a second port, defined collision rules, selectable read-during-write behaviour and a hardware clear.

Parameters:
- addr_width_g, 11, address bits per port; depth = 2**addr_width_g.
- data_width_g, 8, data bits per word.
- rdw_mode_g, 0, same-port read-during-write: 0 = q returns old contents, 1 = q returns the data being written.
- clear_value_g, 0, word written to every location by the clear sequencer; truncated to data_width_g.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; starts a clear sweep.
- clear_req  in  1  one-cycle pulse; starts a clear sweep when idle.
- busy  out  1  high while the clear sweep runs.
- address_a  in  addr_width_g  port A address.
- data_a  in  data_width_g  port A write data.
- wren_a  in  1  port A write enable.
- q_a  out  data_width_g  port A registered read data.
- address_b  in  addr_width_g  port B address.
- data_b  in  data_width_g  port B write data.
- wren_b  in  1  port B write enable.
- q_b  out  data_width_g  port B registered read data.

Behaviour:
- **Reset (sync, high):**
  - state <= CLEAR, clear counter <= 0, busy <= 1, q_a <= 0, q_b <= 0.
  - RAM array contents are not reset directly; the sweep clears them.
  - While reset is held, the state stays CLEAR with counter 0.
- **FSM states:** IDLE, CLEAR.
- **CLEAR:**
  - Each cycle writes clear_value_g to ram[counter], then counter increments.
  - The cycle that writes address 2**addr_width_g-1 moves the state to IDLE.
  - busy falls on that same edge, so busy stays high for exactly 2**addr_width_g cycles after reset deasserts.
  - The counter is addr_width_g bits and wraps to 0 on exit.
- **IDLE:**
  - clear_req=1 -> CLEAR and busy=1 next cycle, counter 0.
  - clear_req during CLEAR is ignored; no restart.
- **Reset mid-sweep:** restarts the sweep from address 0; the full depth is re-cleared.
- **While busy:**
  - wren_a and wren_b are ignored; user writes are dropped, not queued.
  - q_a and q_b are held at 0.
- **Normal read (IDLE):**
  - q_x <= ram[address_x] on the clock edge; latency 1 cycle.
  - q updates every cycle whether or not that port writes.
- **Same-port read-during-write:**
  - rdw_mode_g=0: q_x = previous contents.
  - rdw_mode_g=1: q_x = data_x.
- **Cross-port read-during-write** (port A writes the address port B reads, same cycle): the reader always gets the old contents, in both modes.
- **Write collision** (wren_a and wren_b, equal addresses, same cycle):
  - Port A wins; the location holds data_a after the edge.
  - Port B's own q follows the rdw_mode_g rule using data_a as the written value in mode 1.
- **Width rules:** no arithmetic on data; addresses are used unsigned, with no out-of-range case because depth is a full power of two.
- **Implementation constraint:** must infer block RAM. The clear write shares port A's write path through a mux; no second array.

Test Plan:
- **Reset clear:** addr_width_g=4. Pulse reset 1 cycle, count busy -> high exactly 16 cycles. Then read all 16 addresses on A and B -> all 0x00, each q valid 1 cycle after its address.
- **Dual write/read:**
  - A writes 0xA5 @3 while B writes 0x5A @7.
  - Next cycles, A reads 7 and B reads 3 -> q_a=0x5A, q_b=0xA5.
- **Collision:** same cycle, A writes 0x11 @9 and B writes 0x22 @9. Read @9 -> 0x11.
- **RDW modes:** location 5 holds 0x33; A writes 0x44 @5 with address_a=5.
  - rdw_mode_g=0 -> q_a=0x33 next cycle.
  - rdw_mode_g=1 -> q_a=0x44.
  - In both modes, B reading 5 in the same cycle -> 0x33.
- **Clear request, writes blocked:** fill RAM with 0xFF. Pulse clear_req with clear_value_g=0x80, and hold wren_a=1 data_a=0x01 @2 during busy.
  - busy high 16 cycles; q_a/q_b=0 throughout.
  - Afterwards every location = 0x80, including @2.
- **Reset mid-sweep:** assert reset at counter=10 of a clear_req sweep. busy stays high 16 more cycles after reset release. A second clear_req pulsed during busy does not extend busy.
